// File: rtl/mic_conditioner.sv
// Microphone sample conditioner: offset-binary to signed, optional DC removal,
// shift gain with saturation, registered L/R words with a one-cycle valid strobe.
module mic_conditioner #(
  parameter int DC_SHIFT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [11:0]        sample_in,
  input  logic               sample_valid,
  input  logic [2:0]         gain,
  input  logic               dc_en,
  input  logic               mute,
  input  logic               invert_r,
  input  logic               clip_clr,
  output logic signed [15:0] out_left,
  output logic signed [15:0] out_right,
  output logic               out_valid,
  output logic               clip
);
  localparam int ACC_W = 13 + DC_SHIFT;

  logic                    r_sv_d;
  logic [11:0]             r_samp;
  logic [2:0]              r_vld_pipe;
  logic signed [12:0]      r_d;
  logic signed [15:0]      r_y;
  logic signed [ACC_W-1:0] r_acc;

  logic                    w_accept;
  logic signed [12:0]      w_s, w_dc, w_d;
  logic signed [ACC_W-1:0] w_acc_sh, w_acc_nxt;
  logic [3:0]              w_sh;
  logic signed [23:0]      w_pe, w_p;
  logic                    w_hi, w_lo;
  logic signed [15:0]      w_sat, w_y, w_neg;
  logic                    w_clip_set;

  assign w_accept = sample_valid & ~r_sv_d;

  // Offset-binary to two's complement is an MSB flip, sign-extended to 13 bits.
  assign w_s       = {~r_samp[11], ~r_samp[11], r_samp[10:0]};
  assign w_acc_sh  = r_acc >>> DC_SHIFT;
  assign w_dc      = w_acc_sh[12:0];
  assign w_d       = dc_en ? (w_s - w_dc) : w_s;
  assign w_acc_nxt = r_acc + {{DC_SHIFT{w_s[12]}}, w_s} - {{DC_SHIFT{w_dc[12]}}, w_dc};

  assign w_sh       = {1'b0, gain} + 4'd4;
  assign w_pe       = {{11{r_d[12]}}, r_d};
  assign w_p        = w_pe <<< w_sh;
  assign w_hi       = (w_p > 24'sd32767);
  assign w_lo       = (w_p < -24'sd32768);
  assign w_sat      = w_hi ? 16'sh7FFF : (w_lo ? 16'sh8000 : w_p[15:0]);
  assign w_y        = mute ? 16'sd0 : w_sat;
  assign w_clip_set = r_vld_pipe[1] & ~mute & (w_hi | w_lo);

  // Negating the most negative word would wrap; clamp it to full-scale positive.
  assign w_neg = (r_y == 16'sh8000) ? 16'sh7FFF : -r_y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sv_d     <= 1'b0;
      r_samp     <= '0;
      r_vld_pipe <= '0;
      r_d        <= '0;
      r_y        <= '0;
      r_acc      <= '0;
      out_left   <= '0;
      out_right  <= '0;
      out_valid  <= 1'b0;
      clip       <= 1'b0;
    end else begin
      r_sv_d     <= sample_valid;
      r_vld_pipe <= {r_vld_pipe[1:0], w_accept};
      if (w_accept) r_samp <= sample_in;
      if (r_vld_pipe[0]) begin
        r_d <= w_d;
        if (dc_en) r_acc <= w_acc_nxt;
      end
      if (r_vld_pipe[1]) r_y <= w_y;
      if (r_vld_pipe[2]) begin
        out_left  <= r_y;
        out_right <= invert_r ? w_neg : r_y;
      end
      out_valid <= r_vld_pipe[2];
      if (w_clip_set)    clip <= 1'b1;
      else if (clip_clr) clip <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mic_conditioner.sv
// Directed + randomized bench for mic_conditioner against an arithmetic model.
module tb_mic_conditioner;
  localparam int SH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [11:0] sample_in = '0;
  logic sample_valid = 1'b0;
  logic [2:0] gain = '0;
  logic dc_en = 1'b0, mute = 1'b0, invert_r = 1'b0, clip_clr = 1'b0;
  logic signed [15:0] out_left, out_right;
  logic out_valid, clip;

  int nchk = 0, nerr = 0;
  int nvalid = 0;
  int m_acc = 0;
  int m_clip = 0;
  int obs_q[$];
  int exp_q[$];

  mic_conditioner #(.DC_SHIFT(SH)) dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .gain(gain), .dc_en(dc_en), .mute(mute), .invert_r(invert_r),
    .clip_clr(clip_clr), .out_left(out_left), .out_right(out_right),
    .out_valid(out_valid), .clip(clip)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      nvalid <= nvalid + 1;
      obs_q.push_back(int'(out_left));
    end
  end

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the current control settings.
  task automatic model(input logic [11:0] smp, output int el, output int er);
    int s, dc, d, p, y, dv;
    bit sat;
    dv = 1 << SH;
    s  = int'(smp) - 2048;
    dc = (m_acc >= 0) ? m_acc / dv : -((-m_acc + dv - 1) / dv);
    d  = dc_en ? s - dc : s;
    if (dc_en) m_acc = m_acc + s - dc;
    p = d * (1 << (4 + gain));
    y = (p > 32767) ? 32767 : ((p < -32768) ? -32768 : p);
    sat = (y != p);
    if (mute) begin y = 0; sat = 0; end
    if (sat) m_clip = 1;
    el = y;
    er = invert_r ? ((y == -32768) ? 32767 : -y) : y;
  endtask

  task automatic send(input logic [11:0] smp, output int got_l);
    int el, er, lat;
    @(negedge clk);
    sample_in = smp; sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    model(smp, el, er);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 3);
    chk("out_left", out_left, el);
    chk("out_right", out_right, er);
    chk("clip", clip, m_clip);
    got_l = int'(out_left);
    @(negedge clk);
    chk("valid_one_cycle", out_valid, 0);
  endtask

  task automatic clear_clip();
    @(negedge clk); clip_clr = 1'b1;
    @(negedge clk); clip_clr = 1'b0;
    m_clip = 0;
  endtask

  initial begin
    int got, prev, el, er, n0;
    // Reset with sample_valid toggling
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sample_valid = ~sample_valid;
      chk("rst_left", out_left, 0);
      chk("rst_right", out_right, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_clip", clip, 0);
    end
    @(negedge clk); sample_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("no_out_after_release", nvalid, 0);

    // Basic path
    send(12'hC00, got); chk("basic_c00", got, 16'h4000);
    send(12'h800, got); chk("basic_800", got, 0);

    // Saturation and invert
    gain = 3'd3; invert_r = 1'b1;
    send(12'hFFF, got); chk("sat_pos", got, 32767);
    chk("sat_pos_r", out_right, -32767);
    chk("clip_set", clip, 1);
    send(12'h000, got); chk("sat_neg", got, -32768);
    chk("sat_neg_r", out_right, 32767);
    clear_clip();
    chk("clip_clr", clip, 0);

    // Randomized settings, changed only while the pipeline is idle
    for (int i = 0; i < 40; i++) begin
      gain = 3'($urandom_range(0, 7));
      invert_r = 1'($urandom);
      mute = ($urandom_range(0, 5) == 0);
      dc_en = 1'($urandom);
      if ($urandom_range(0, 7) == 0) clear_clip();
      send(12'($urandom), got);
    end

    // DC removal from a zeroed accumulator
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    m_acc = 0; m_clip = 0;
    gain = 3'd0; invert_r = 1'b0; mute = 1'b0; dc_en = 1'b1;
    prev = 32767;
    for (int i = 0; i < 200; i++) begin
      send(12'h900, got);
      if (i == 0) chk("dc_first", got, 16'h1000);
      if (got > prev) chk("dc_monotonic", got, prev);
      prev = got;
    end
    chk("dc_final_small", (prev <= 16 && prev >= -16), 1);
    dc_en = 1'b0;
    send(12'h900, got); chk("dc_off", got, 16'h1000);
    send(12'h900, got); chk("dc_frozen", got, 16'h1000);

    // Held-high sample_valid gives one accept
    n0 = nvalid;
    @(negedge clk); sample_in = 12'hA00; sample_valid = 1'b1;
    model(12'hA00, el, er);
    repeat (10) @(negedge clk);
    sample_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("held_one_valid", nvalid - n0, 1);
    chk("held_value", out_left, el);

    // Accepts every 2 cycles, in order
    gain = 3'd2;
    obs_q.delete(); exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      logic [11:0] smp;
      smp = 12'($urandom);
      @(negedge clk); sample_in = smp; sample_valid = 1'b1;
      model(smp, el, er);
      exp_q.push_back(el);
      @(negedge clk); sample_valid = 1'b0;
    end
    repeat (6) @(negedge clk);
    chk("burst_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk("burst_value", obs_q[i], exp_q[i]);

    // Mute: zero output, strobe still present, clip untouched
    clear_clip();
    gain = 3'd7; mute = 1'b1;
    send(12'hFFF, got); chk("mute_zero", got, 0);
    chk("mute_clip", clip, 0);
    mute = 1'b0; gain = 3'd0;

    // Reset between edges k+1 and k+2
    dc_en = 1'b1;
    n0 = nvalid;
    @(negedge clk); sample_in = 12'hF00; sample_valid = 1'b1;
    @(negedge clk); sample_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("rst_mid_no_valid", nvalid - n0, 0);
    chk("rst_mid_left", out_left, 0);
    chk("rst_mid_right", out_right, 0);
    m_acc = 0; m_clip = 0;
    send(12'h900, got); chk("rst_mid_fresh_acc", got, 16'h1000);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
